// File: rtl/t2mi_frame_scheduler.sv
// Per-T2-frame command sequencer for the T2-MI packer: issues BB-frame, timestamp
// and L1 commands over valid/ready and owns every frame, packet and timestamp counter.
module t2mi_frame_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [7:0]  num_t2_frames,
  input  logic [9:0]  plp_num_blocks,
  input  logic [26:0] T_sf_ssu,
  output logic        CMD_VALID,
  input  logic        CMD_RDY,
  output logic [1:0]  CMD_TYPE,
  output logic [7:0]  CMD_PACKET_COUNT,
  output logic [7:0]  CMD_FRAME_IDX,
  output logic [3:0]  CMD_SUPERFRAME_IDX,
  output logic        CMD_IFS,
  output logic [26:0] CMD_SUBSECONDS,
  input  logic        PKT_DONE,
  output logic        BUSY,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned TMO_W  = 16;
  localparam int unsigned NF_W   = 8;
  localparam int unsigned NB_W   = 10;
  localparam int unsigned SF_W   = 4;
  localparam int unsigned SS_W   = 27;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] TYPE_BB = 2'd0;
  localparam logic [1:0] TYPE_TS = 2'd1;
  localparam logic [1:0] TYPE_L1 = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_ADVANCE} state_e;

  state_e            state_q;
  logic              valid_q, busy_q, err_q, ifs_q, done_ok_q;
  logic [1:0]        type_q;
  logic [NB_W-1:0]   bb_idx_q, nb_q;
  logic [NF_W-1:0]   nf_q, frame_q, pkt_cnt_q;
  logic [SF_W-1:0]   sf_q;
  logic [SS_W-1:0]   ss_q;
  logic [TMO_W-1:0]  tmo_cnt_q;

  logic [1:0]        type_d;
  logic [NB_W-1:0]   bb_idx_d, nb_in;
  logic [NF_W-1:0]   nf_in;
  logic              ifs_d, eof_d;

  assign nf_in = (num_t2_frames == '0) ? NF_W'(1) : num_t2_frames;
  assign nb_in = (plp_num_blocks == '0) ? NB_W'(1) : plp_num_blocks;

  // Next packet slot after the current one; eof_d marks the L1 packet closing a T2 frame.
  always_comb begin
    type_d   = type_q;
    bb_idx_d = bb_idx_q;
    eof_d    = 1'b0;
    case (type_q)
      TYPE_BB: begin
        if (bb_idx_q >= nb_q - NB_W'(1)) type_d = TYPE_TS;
        else                             bb_idx_d = bb_idx_q + NB_W'(1);
      end
      TYPE_TS: type_d = TYPE_L1;
      default: begin
        type_d   = TYPE_BB;
        bb_idx_d = '0;
        eof_d    = 1'b1;
      end
    endcase
    ifs_d = (type_d == TYPE_BB) && (bb_idx_d == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      ifs_q     <= 1'b0;
      done_ok_q <= 1'b0;
      type_q    <= TYPE_BB;
      bb_idx_q  <= '0;
      nb_q      <= '0;
      nf_q      <= '0;
      frame_q   <= '0;
      pkt_cnt_q <= '0;
      sf_q      <= '0;
      ss_q      <= '0;
      tmo_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ENABLE) begin
            state_q <= ST_ISSUE;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            nf_q    <= nf_in;
            nb_q    <= nb_in;
            ifs_q   <= (type_q == TYPE_BB) && (bb_idx_q == '0);
          end
        end
        ST_ISSUE: begin
          if (CMD_RDY) begin
            state_q   <= ST_WAIT_DONE;
            valid_q   <= 1'b0;
            tmo_cnt_q <= '0;
          end
        end
        // A done pulse in the timeout cycle takes priority over the error.
        ST_WAIT_DONE: begin
          if (PKT_DONE) begin
            done_ok_q <= 1'b1;
            state_q   <= ST_ADVANCE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q     <= 1'b1;
            done_ok_q <= 1'b0;
            state_q   <= ST_ADVANCE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_ADVANCE: begin
          if (done_ok_q) pkt_cnt_q <= pkt_cnt_q + NF_W'(1);
          type_q   <= type_d;
          bb_idx_q <= bb_idx_d;
          ifs_q    <= ifs_d;
          if (eof_d) begin
            nf_q <= nf_in;
            nb_q <= nb_in;
            if (frame_q >= nf_q - NF_W'(1)) begin
              frame_q <= '0;
              sf_q    <= sf_q + SF_W'(1);
              ss_q    <= ss_q + T_sf_ssu;
            end else begin
              frame_q <= frame_q + NF_W'(1);
            end
          end
          valid_q <= ENABLE;
          busy_q  <= ENABLE;
          state_q <= ENABLE ? ST_ISSUE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_VALID          = valid_q;
  assign CMD_TYPE           = type_q;
  assign CMD_PACKET_COUNT   = pkt_cnt_q;
  assign CMD_FRAME_IDX      = frame_q;
  assign CMD_SUPERFRAME_IDX = sf_q;
  assign CMD_IFS            = ifs_q;
  assign CMD_SUBSECONDS     = ss_q;
  assign BUSY               = busy_q;
  assign TIMEOUT_ERR        = err_q;

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Bench for t2mi_frame_scheduler: directed and randomized packet traffic checked every
// cycle against a packet-level model of the T2-MI command sequence.
module tb_t2mi_frame_scheduler;

  localparam int unsigned TMO = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE, CMD_RDY, PKT_DONE;
  logic [7:0]  num_t2_frames;
  logic [9:0]  plp_num_blocks;
  logic [26:0] T_sf_ssu;
  logic        CMD_VALID, CMD_IFS, BUSY, TIMEOUT_ERR;
  logic [1:0]  CMD_TYPE;
  logic [7:0]  CMD_PACKET_COUNT, CMD_FRAME_IDX;
  logic [3:0]  CMD_SUPERFRAME_IDX;
  logic [26:0] CMD_SUBSECONDS;

  int errors = 0;
  int checks = 0;

  // Packet-level model: slot 0..nb-1 are BB frames, nb is timestamp, nb+1 is L1.
  int     m_nf, m_nb, m_slot, m_frame, m_sf, m_pc;
  longint m_ss;
  bit     m_err;

  int log_type[8], log_ifs[8], log_frame[8];
  int exp_type[8]  = '{0, 0, 1, 2, 0, 0, 1, 2};
  int exp_ifs[8]   = '{1, 0, 0, 0, 1, 0, 0, 0};
  int exp_frame[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  t2mi_frame_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .num_t2_frames(num_t2_frames), .plp_num_blocks(plp_num_blocks), .T_sf_ssu(T_sf_ssu),
    .CMD_VALID(CMD_VALID), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
    .CMD_PACKET_COUNT(CMD_PACKET_COUNT), .CMD_FRAME_IDX(CMD_FRAME_IDX),
    .CMD_SUPERFRAME_IDX(CMD_SUPERFRAME_IDX), .CMD_IFS(CMD_IFS),
    .CMD_SUBSECONDS(CMD_SUBSECONDS), .PKT_DONE(PKT_DONE), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic m_reset();
    m_nf = 1; m_nb = 1; m_slot = 0; m_frame = 0; m_sf = 0; m_pc = 0; m_ss = 0; m_err = 1'b0;
  endtask

  task automatic m_latch();
    m_nf = (num_t2_frames == 8'd0) ? 1 : int'(num_t2_frames);
    m_nb = (plp_num_blocks == 10'd0) ? 1 : int'(plp_num_blocks);
  endtask

  task automatic m_advance(input bit completed);
    if (completed) m_pc = (m_pc + 1) % 256;
    m_slot++;
    if (m_slot == m_nb + 2) begin
      m_slot = 0;
      if (m_frame + 1 >= m_nf) begin
        m_frame = 0;
        m_sf    = (m_sf + 1) % 16;
        m_ss    = (m_ss + longint'(T_sf_ssu)) % (longint'(1) << 27);
      end else begin
        m_frame++;
      end
      m_latch();
    end
  endtask

  task automatic check_idle();
    chk("idle_valid", 32'(CMD_VALID), 32'(0));
    chk("idle_busy", 32'(BUSY), 32'(0));
    chk("idle_err", 32'(TIMEOUT_ERR), 32'(m_err));
  endtask

  task automatic check_cmd();
    int et;
    et = (m_slot < m_nb) ? 0 : ((m_slot == m_nb) ? 1 : 2);
    chk("cmd_valid", 32'(CMD_VALID), 32'(1));
    chk("cmd_busy", 32'(BUSY), 32'(1));
    chk("cmd_type", 32'(CMD_TYPE), 32'(et));
    chk("cmd_ifs", 32'(CMD_IFS), 32'(m_slot == 0));
    chk("cmd_pkt_cnt", 32'(CMD_PACKET_COUNT), 32'(m_pc));
    chk("cmd_frame", 32'(CMD_FRAME_IDX), 32'(m_frame));
    chk("cmd_sf", 32'(CMD_SUPERFRAME_IDX), 32'(m_sf));
    chk("cmd_subsec", 32'(CMD_SUBSECONDS), 32'(m_ss));
    chk("cmd_err", 32'(TIMEOUT_ERR), 32'(m_err));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    ENABLE = 1'b0; CMD_RDY = 1'b0; PKT_DONE = 1'b0;
    RST = 1'b0;
    #1;
    chk("rst_valid", 32'(CMD_VALID), 32'(0));
    chk("rst_type", 32'(CMD_TYPE), 32'(0));
    chk("rst_pkt_cnt", 32'(CMD_PACKET_COUNT), 32'(0));
    chk("rst_frame", 32'(CMD_FRAME_IDX), 32'(0));
    chk("rst_sf", 32'(CMD_SUPERFRAME_IDX), 32'(0));
    chk("rst_ifs", 32'(CMD_IFS), 32'(0));
    chk("rst_subsec", 32'(CMD_SUBSECONDS), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_err", 32'(TIMEOUT_ERR), 32'(0));
    @(negedge CLK);
    RST = 1'b1;
    m_reset();
    step();
    check_idle();
  endtask

  task automatic start_run();
    check_idle();
    ENABLE = 1'b1;
    m_latch();
    step();
  endtask

  // Called at the negedge of the first ISSUE cycle of a packet.
  task automatic run_packet(input int rdy_dly, input int done_dly, input bit en_after,
                            input bit spurious);
    int  w;
    bit  timed_out;
    check_cmd();
    CMD_RDY = (rdy_dly == 0);
    for (int i = 0; i < rdy_dly; i++) begin
      PKT_DONE = spurious;
      step();
      PKT_DONE = 1'b0;
      check_cmd();
      CMD_RDY = (i == rdy_dly - 1);
    end
    step();
    CMD_RDY = 1'($urandom_range(0, 1));
    ENABLE  = en_after;
    chk("hs_valid_drop", 32'(CMD_VALID), 32'(0));
    chk("wait_busy", 32'(BUSY), 32'(1));
    timed_out = (done_dly > int'(TMO));
    w = timed_out ? int'(TMO) : done_dly;
    for (int i = 1; i <= w; i++) begin
      if (i == done_dly) PKT_DONE = 1'b1;
      step();
      PKT_DONE = 1'b0;
      if (i < w) begin
        chk("wait_valid", 32'(CMD_VALID), 32'(0));
        chk("wait_err", 32'(TIMEOUT_ERR), 32'(m_err));
      end
    end
    if (timed_out) m_err = 1'b1;
    chk("adv_valid", 32'(CMD_VALID), 32'(0));
    chk("adv_busy", 32'(BUSY), 32'(1));
    chk("adv_err", 32'(TIMEOUT_ERR), 32'(m_err));
    m_advance(!timed_out);
    CMD_RDY = 1'($urandom_range(0, 1));
    step();
    if (!en_after) check_idle();
  endtask

  task automatic resume(input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) begin
      PKT_DONE = (i == 0);
      CMD_RDY  = 1'b1;
      step();
      PKT_DONE = 1'b0;
      check_idle();
    end
    CMD_RDY = 1'b0;
    ENABLE  = 1'b1;
    m_latch();
    step();
  endtask

  initial begin
    ENABLE = 1'b0; CMD_RDY = 1'b0; PKT_DONE = 1'b0;
    num_t2_frames = 8'd2; plp_num_blocks = 10'd2; T_sf_ssu = 27'd12345;
    m_reset();
    #1;
    do_reset();

    // Basic sequence N_B=2, N_F=2, done 5 cycles after each handshake.
    start_run();
    for (int i = 0; i < 8; i++) begin
      log_type[i]  = int'(CMD_TYPE);
      log_ifs[i]   = int'(CMD_IFS);
      log_frame[i] = int'(CMD_FRAME_IDX);
      run_packet(0, 5, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      chk("seq_type", 32'(log_type[i]), 32'(exp_type[i]));
      chk("seq_frame", 32'(log_frame[i]), 32'(exp_frame[i]));
      if (exp_type[i] == 0) chk("seq_ifs", 32'(log_ifs[i]), 32'(exp_ifs[i]));
    end
    chk("sf_after_2_frames", 32'(CMD_SUPERFRAME_IDX), 32'(1));
    chk("frame_after_2_frames", 32'(CMD_FRAME_IDX), 32'(0));
    chk("subsec_after_sf", 32'(CMD_SUBSECONDS), 32'(12345));
    chk("pkt_cnt_after_8", 32'(CMD_PACKET_COUNT), 32'(8));

    // Backpressure for 10 cycles with spurious done pulses during ISSUE.
    run_packet(10, 3, 1'b1, 1'b1);
    chk("pkt_cnt_after_stall", 32'(CMD_PACKET_COUNT), 32'(9));

    // Done in the very cycle the timeout expires: done wins.
    run_packet(0, int'(TMO), 1'b1, 1'b0);
    chk("boundary_no_err", 32'(TIMEOUT_ERR), 32'(0));
    chk("boundary_pkt_cnt", 32'(CMD_PACKET_COUNT), 32'(10));

    // Real timeout: error sticks, slot consumed, packet_count held.
    run_packet(0, int'(TMO) + 3, 1'b1, 1'b0);
    chk("timeout_err", 32'(TIMEOUT_ERR), 32'(1));
    chk("timeout_pkt_cnt", 32'(CMD_PACKET_COUNT), 32'(10));
    run_packet(0, 2, 1'b1, 1'b0);
    chk("post_timeout_pkt_cnt", 32'(CMD_PACKET_COUNT), 32'(11));

    // Reset in the middle of WAIT_DONE.
    check_cmd();
    CMD_RDY = 1'b1;
    step();
    do_reset();

    // ENABLE dropped during BB slot 1, then resumed at the timestamp slot.
    num_t2_frames = 8'd2; plp_num_blocks = 10'd2;
    start_run();
    run_packet(0, 3, 1'b1, 1'b0);
    run_packet(1, 4, 1'b0, 1'b0);
    chk("parked_busy", 32'(BUSY), 32'(0));
    resume(4);
    chk("resume_type", 32'(CMD_TYPE), 32'(1));
    chk("resume_pkt_cnt", 32'(CMD_PACKET_COUNT), 32'(2));
    run_packet(0, 2, 1'b1, 1'b0);

    // Zero sizes (treated as 1), superframe wrap, subseconds wrap, packet_count wrap.
    do_reset();
    num_t2_frames = 8'd0; plp_num_blocks = 10'd0; T_sf_ssu = 27'h4000000;
    start_run();
    for (int k = 0; k < 260; k++) begin
      if (k == 3)   chk("subsec_1sf", 32'(CMD_SUBSECONDS), 32'h4000000);
      if (k == 6)   chk("subsec_wrap", 32'(CMD_SUBSECONDS), 32'(0));
      if (k == 45)  chk("sf_15", 32'(CMD_SUPERFRAME_IDX), 32'(15));
      if (k == 48)  chk("sf_wrap", 32'(CMD_SUPERFRAME_IDX), 32'(0));
      if (k == 255) chk("pkt_cnt_255", 32'(CMD_PACKET_COUNT), 32'(255));
      if (k == 256) chk("pkt_cnt_wrap", 32'(CMD_PACKET_COUNT), 32'(0));
      run_packet(int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), 1'b1,
                 1'($urandom_range(0, 1)));
    end

    // Randomized traffic: delays, timeouts, enable drops, frame-boundary size changes.
    do_reset();
    num_t2_frames  = 8'($urandom_range(0, 3));
    plp_num_blocks = 10'($urandom_range(0, 4));
    T_sf_ssu       = 27'($urandom);
    start_run();
    for (int k = 0; k < 300; k++) begin
      int  rd, dd;
      bit  en;
      rd = int'($urandom_range(0, 3));
      dd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO, TMO + 3))
                                       : int'($urandom_range(1, 6));
      en = ($urandom_range(0, 7) != 0);
      if (m_slot == m_nb + 1 && $urandom_range(0, 2) == 0) begin
        num_t2_frames  = 8'($urandom_range(0, 3));
        plp_num_blocks = 10'($urandom_range(0, 4));
        T_sf_ssu       = 27'($urandom);
      end
      run_packet(rd, dd, en, 1'($urandom_range(0, 1)));
      if (!en) resume(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
